spi_wb_initiator: RTL and testbench

Converts the byte stream delivered by the SPI target (already deserialized and synchronized to the 64 MHz system clock) into single-beat Wishbone classic read/write cycles on the 20-bit system bus (WB_ADDR_WIDTH = 20, DATA_WIDTH = 8). It sits directly downstream of the SPI byte receiver and upstream of the Wishbone interconnect. It keeps an auto-incrementing address register so the MCU can stream sequential accesses, and it returns read data for shift-out on the following SPI byte.

---
 rtl/spi_wb_initiator.sv | 218 +++++++++++++++++++++
 tb/tb_spi_wb_initiator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_initiator.sv
// spi_wb_initiator
// Turns the command/address/data byte stream from the SPI receiver into
// single-beat Wishbone classic cycles. The address register auto-increments
// after every acknowledged cycle. The last read result is held on spi_data_o
// so it can be shifted out during the next SPI byte.
module spi_wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        spi_start_i,
  input  logic        spi_valid_i,
  input  logic [7:0]  spi_data_i,
  output logic [7:0]  spi_data_o,
  output logic [19:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        status_clear_i,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int unsigned CntW = 5;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_BUS     = 3'd4
  } state_e;

  state_e          state_q, state_d, eff_state;
  logic [19:0]     addr_q, addr_d;
  // Upper 12 address bits collected while the address bytes arrive; the real
  // address register is only updated once the last address byte is in, so an
  // aborted command leaves the stored address untouched.
  logic [11:0]     ahi_q, ahi_d;
  logic            rd_q, rd_d;
  logic [7:0]      wdat_q, wdat_d;
  logic [7:0]      rdat_q, rdat_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovr_q, ovr_d;
  logic            tmo_q, tmo_d;
  logic            set_ovr, set_tmo;

  // Next-state, datapath and sticky-flag logic.
  always_comb begin
    addr_d  = addr_q;
    ahi_d   = ahi_q;
    rd_d    = rd_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    set_ovr = 1'b0;
    set_tmo = 1'b0;

    // A frame start discards any partial command, but never a running bus cycle.
    if ((state_q != ST_BUS) && spi_start_i) begin
      eff_state = ST_CMD;
    end else begin
      eff_state = state_q;
    end
    state_d = eff_state;

    case (eff_state)
      ST_CMD: begin
        if (spi_valid_i) begin
          rd_d = spi_data_i[6];
          if (spi_data_i[7]) begin
            ahi_d   = {spi_data_i[3:0], 8'h00};
            state_d = ST_ADDR_HI;
          end else if (spi_data_i[6]) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            cnt_d   = 5'd0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_ADDR_HI: begin
        if (spi_valid_i) begin
          ahi_d   = {ahi_q[11:8], spi_data_i};
          state_d = ST_ADDR_LO;
        end else begin
          state_d = ST_ADDR_HI;
        end
      end
      ST_ADDR_LO: begin
        if (spi_valid_i) begin
          addr_d = {ahi_q, spi_data_i};
          if (rd_q) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            cnt_d   = 5'd0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_ADDR_LO;
        end
      end
      ST_DATA: begin
        if (spi_valid_i) begin
          wdat_d  = spi_data_i;
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_BUS: begin
        // Any byte arriving now is dropped; the bus cycle carries on.
        set_ovr = spi_valid_i;
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = addr_q + 20'd1;
          state_d = ST_CMD;
          if (we_q) begin
            rdat_d = rdat_q;
          end else begin
            rdat_d = wb_dat_i;
          end
        end else if (cnt_q == TmoLast) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          set_tmo = 1'b1;
          state_d = ST_CMD;
          if (we_q) begin
            rdat_d = rdat_q;
          end else begin
            rdat_d = 8'hFF;
          end
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = ST_BUS;
        end
      end
      default: begin
        state_d = ST_CMD;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    // Setting events take priority over a simultaneous clear.
    if (set_ovr) begin
      ovr_d = 1'b1;
    end else if (status_clear_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (set_tmo) begin
      tmo_d = 1'b1;
    end else if (status_clear_i) begin
      tmo_d = 1'b0;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // State and datapath registers; reset drops an in-flight bus cycle at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_CMD;
      addr_q  <= 20'h00000;
      ahi_q   <= 12'h000;
      rd_q    <= 1'b0;
      wdat_q  <= 8'h00;
      rdat_q  <= 8'h00;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 5'd0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ahi_q   <= ahi_d;
      rd_q    <= rd_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign spi_data_o = rdat_q;
  assign wb_adr_o   = addr_q;
  assign wb_dat_o   = wdat_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign overrun_o  = ovr_q;
  assign timeout_o  = tmo_q;

endmodule

// File: tb/tb_spi_wb_initiator.sv
// Self-checking bench for spi_wb_initiator: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_spi_wb_initiator;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        spi_start_i = 1'b0;
  logic        spi_valid_i = 1'b0;
  logic [7:0]  spi_data_i = 8'h00;
  logic [7:0]  spi_data_o;
  logic [19:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        status_clear_i = 1'b0;
  logic        overrun_o;
  logic        timeout_o;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model state.
  logic [19:0] m_addr = 20'h00000;
  logic [7:0]  m_dat  = 8'h00;
  logic [7:0]  m_spi  = 8'h00;
  logic        m_ovr  = 1'b0;
  logic        m_tmo  = 1'b0;

  spi_wb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .spi_start_i    (spi_start_i),
    .spi_valid_i    (spi_valid_i),
    .spi_data_i     (spi_data_i),
    .spi_data_o     (spi_data_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_we_o        (wb_we_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_ack_i       (wb_ack_i),
    .status_clear_i (status_clear_i),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'(1'b0));
    chk({tag, "_spi"}, 32'(spi_data_o), 32'(m_spi));
    chk({tag, "_wdat"}, 32'(wb_dat_o), 32'(m_dat));
    chk({tag, "_ovr"}, 32'(overrun_o), 32'(m_ovr));
    chk({tag, "_tmo"}, 32'(timeout_o), 32'(m_tmo));
  endtask

  // Present one byte for one cycle, optionally followed by idle cycles.
  task automatic send(input logic [7:0] b, input bit st, input bit gap);
    spi_valid_i = 1'b1;
    spi_data_i  = b;
    spi_start_i = st;
    @(negedge clk);
    spi_valid_i = 1'b0;
    spi_start_i = 1'b0;
    spi_data_i  = 8'($urandom);
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Act as the Wishbone slave for one cycle and check the initiator side.
  task automatic bus_cycle(input logic [19:0] ea, input bit ew, input logic [7:0] ed,
                           input int waits, input bit never, input logic [7:0] rdata,
                           input bit inj, input bit clr);
    int n;
    n = 0;
    chk("cyc_rise", 32'(wb_cyc_o), 32'(1'b1));
    while (wb_cyc_o && n < 64) begin
      chk("stb_eq_cyc", 32'(wb_stb_o), 32'(1'b1));
      chk("bus_adr", 32'(wb_adr_o), 32'(ea));
      chk("bus_we", 32'(wb_we_o), 32'(ew));
      if (ew) chk("bus_wdat", 32'(wb_dat_o), 32'(ed));
      spi_valid_i    = inj && (n == 1);
      spi_data_i     = 8'($urandom);
      status_clear_i = clr && (n == 1);
      spi_start_i    = inj && (n == 2);
      if (!never && n == waits) begin
        wb_ack_i = 1'b1;
        wb_dat_i = rdata;
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    wb_ack_i       = 1'b0;
    spi_valid_i    = 1'b0;
    spi_start_i    = 1'b0;
    status_clear_i = 1'b0;
    chk("cyc_len", 32'(n), never ? 32'(TMO) : 32'(waits + 1));
  endtask

  // One complete command: a = address follows, r = read.
  task automatic txn(input bit a, input bit r, input logic [19:0] adr, input logic [7:0] d,
                     input int waits, input bit never, input logic [7:0] rdata,
                     input bit inj, input bit clr, input bit st);
    logic [7:0]  cmd;
    logic [19:0] ea;
    cmd = {a, r, 2'($urandom), a ? adr[19:16] : 4'($urandom)};
    send(cmd, st, a || !r);
    if (a) begin
      send(adr[15:8], 1'b0, 1'b1);
      send(adr[7:0], 1'b0, !r);
    end
    if (!r) send(d, 1'b0, 1'b0);
    ea = a ? adr : m_addr;
    if (!r) m_dat = d;
    bus_cycle(ea, !r, m_dat, waits, never, rdata, inj, clr);
    if (clr) begin
      m_ovr = 1'b0;
      m_tmo = 1'b0;
    end
    if (inj) m_ovr = 1'b1;
    if (never) begin
      m_tmo  = 1'b1;
      m_addr = ea;
      if (r) m_spi = 8'hFF;
    end else begin
      m_addr = 20'(ea + 20'd1);
      if (r) m_spi = rdata;
    end
    chk_idle_outputs("post_txn");
  endtask

  task automatic clear_flags();
    status_clear_i = 1'b1;
    @(negedge clk);
    status_clear_i = 1'b0;
    m_ovr = 1'b0;
    m_tmo = 1'b0;
    chk("clr_ovr", 32'(overrun_o), 32'(1'b0));
    chk("clr_tmo", 32'(timeout_o), 32'(1'b0));
  endtask

  // Start a command, then abandon it with a bare frame start.
  task automatic abort_partial(input int k);
    if (k == 2) begin
      send({2'b00, 2'($urandom), 4'($urandom)}, 1'b0, 1'b1);
    end else begin
      send({1'b1, 1'($urandom), 2'($urandom), 4'($urandom)}, 1'b0, 1'b1);
      if (k == 1) send(8'($urandom), 1'b0, 1'b1);
    end
    spi_start_i = 1'b1;
    @(negedge clk);
    spi_start_i = 1'b0;
    chk_idle_outputs("abort");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'(1'b0));
    chk("rst_stb", 32'(wb_stb_o), 32'(1'b0));
    chk("rst_we", 32'(wb_we_o), 32'(1'b0));
    chk("rst_adr", 32'(wb_adr_o), 32'(20'h00000));
    chk("rst_wdat", 32'(wb_dat_o), 32'(8'h00));
    chk("rst_spi", 32'(spi_data_o), 32'(8'h00));
    chk("rst_ovr", 32'(overrun_o), 32'(1'b0));
    chk("rst_tmo", 32'(timeout_o), 32'(1'b0));
    reset_i = 1'b0;
    @(negedge clk);

    // Write with address, then streamed read with 3 wait states.
    txn(1'b1, 1'b0, 20'hA1234, 8'h5C, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    txn(1'b0, 1'b1, 20'h00000, 8'h00, 3, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("stream_next_addr", 32'(m_addr), 32'(20'hA1236));

    // Address wrap.
    txn(1'b1, 1'b0, 20'hFFFFF, 8'hA5, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 1'b0, 20'h00000, 8'h11, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Timeout on read, then clear, then re-read proves no increment.
    txn(1'b1, 1'b1, 20'h00010, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    clear_flags();
    txn(1'b0, 1'b1, 20'h00000, 8'h00, 0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Abort partial commands; the next plain read uses the stored address.
    abort_partial(1);
    txn(1'b0, 1'b1, 20'h00000, 8'h00, 2, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    abort_partial(2);

    // Overrun during a bus cycle, with a same-cycle clear that must lose.
    txn(1'b1, 1'b0, 20'h12345, 8'hC3, 4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset while a bus cycle is in flight.
    send(8'h40, 1'b0, 1'b0);
    chk("pre_rst_cyc", 32'(wb_cyc_o), 32'(1'b1));
    #2 reset_i = 1'b1;
    #1;
    m_addr = 20'h00000;
    m_dat  = 8'h00;
    m_spi  = 8'h00;
    m_ovr  = 1'b0;
    m_tmo  = 1'b0;
    chk("async_rst_stb", 32'(wb_stb_o), 32'(1'b0));
    chk("async_rst_we", 32'(wb_we_o), 32'(1'b0));
    chk("async_rst_adr", 32'(wb_adr_o), 32'(20'h00000));
    chk_idle_outputs("async_rst");
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    txn(1'b0, 1'b1, 20'h00000, 8'h00, 1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      bit          a, r, nv, inj, clr, st;
      int          w;
      logic [19:0] ad;
      a   = 1'($urandom);
      r   = 1'($urandom);
      st  = 1'($urandom);
      nv  = ($urandom_range(0, 7) == 0);
      inj = ($urandom_range(0, 5) == 0);
      clr = inj && ($urandom_range(0, 1) == 1);
      w   = inj ? int'($urandom_range(3, 8)) : int'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) ad = 20'hFFFFF - 20'($urandom_range(0, 2));
      else ad = 20'($urandom);
      if ($urandom_range(0, 5) == 0) abort_partial(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 4) == 0) clear_flags();
      txn(a, r, ad, 8'($urandom), w, nv, 8'($urandom), inj, clr, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
